instr_issue_seq: RTL and testbench

Instruction fetch and issue sequencer: the block that drives the control decoder's 6-bit opcode input and consumes its `nPC_sel` output. It owns the program counter and fetches 32-bit instruction words over a request/valid memory port. It presents one instruction per issue slot to the decoder and datapath, and computes the next PC as sequential or branch-taken. It sits between instruction memory and the combinational control decoder in the single-issue datapath.

---
 rtl/isa_pkg.sv | 39 +++
 rtl/fetch_pc_next.sv | 29 ++
 rtl/instr_issue_seq.sv | 138 +++++++++++++
 tb/tb_instr_issue_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isa_pkg
//  Description : Opcode map, instruction field positions and sequencer state
//                encoding shared by the fetch/issue sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package isa_pkg;

    localparam logic [5:0] OP_LW    = 6'b000000;
    localparam logic [5:0] OP_SW    = 6'b000001;
    localparam logic [5:0] OP_BEQ   = 6'b000010;
    localparam logic [5:0] OP_ADD   = 6'b000011;
    localparam logic [5:0] OP_SUB   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_DIV   = 6'b000110;
    localparam logic [5:0] OP_FLOAT = 6'b000111;

    localparam logic [5:0] OP_MAX_LEGAL = OP_FLOAT;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op <= OP_MAX_LEGAL);
    endfunction

endpackage : isa_pkg
`default_nettype wire

// File: rtl/fetch_pc_next.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_next
//  Description : Next-PC adder: PC+1, or PC+1+sext(imm16) when taken, modulo
//                2^AW.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_next #(
    parameter int unsigned AW = 8
) (
    input  logic [AW-1:0] pc,
    input  logic [15:0]   imm16,
    input  logic          taken,
    output logic [AW-1:0] next_pc
);

    logic [AW-1:0] w_imm;

    // Dropping the high bits of the offset is exact under modulo-2^AW arithmetic.
    if (AW <= 16) begin : g_imm_trunc
        assign w_imm = imm16[AW-1:0];
    end else begin : g_imm_sext
        assign w_imm = {{(AW-16){imm16[15]}}, imm16};
    end

    assign next_pc = pc + AW'(1) + (taken ? w_imm : '0);

endmodule : fetch_pc_next
`default_nettype wire

// File: rtl/instr_issue_seq.sv
`default_nettype none
// ============================================================================
//  Module      : instr_issue_seq
//  Description : Single-issue fetch/issue sequencer owning the PC, feeding the
//                combinational decoder and consuming its branch decision.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_issue_seq
    import isa_pkg::*;
#(
    parameter int unsigned   AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          imem_valid,
    output logic [5:0]    comman,
    output logic [31:0]   instr,
    output logic          issue_valid,
    input  logic          nPC_sel,
    input  logic          stall,
    output logic          halted,
    output logic          illegal
);

    state_e        r_state_q,    w_state_d;
    logic [AW-1:0] r_pc_q,       w_pc_d;
    logic [31:0]   r_instr_q,    w_instr_d;
    logic          r_br_taken_q, w_br_taken_d;
    logic          r_illegal_q,  w_illegal_d;
    logic          r_imem_req_q;
    logic          r_issue_valid_q;
    logic          r_halted_q;

    logic [AW-1:0] w_next_pc;
    logic          w_taken_sel;

    // In ISSUE the decoder answer is live; in WAIT only the latched copy counts.
    assign w_taken_sel = (r_state_q == ST_ISSUE) ? nPC_sel : r_br_taken_q;

    fetch_pc_next #(
        .AW (AW)
    ) u_pc_next (
        .pc      (r_pc_q),
        .imm16   (r_instr_q[IMM_MSB:IMM_LSB]),
        .taken   (w_taken_sel),
        .next_pc (w_next_pc)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_pc_d       = r_pc_q;
        w_instr_d    = r_instr_q;
        w_br_taken_d = r_br_taken_q;
        w_illegal_d  = r_illegal_q;
        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_pc_d    = RESET_PC;
                    w_state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    w_instr_d = imem_rdata;
                    if (is_legal_op(imem_rdata[OPC_MSB:OPC_LSB])) begin
                        w_state_d = ST_ISSUE;
                    end else begin
                        w_illegal_d = 1'b1;
                        w_state_d   = ST_HALT;
                    end
                end
            end
            ST_ISSUE: begin
                w_br_taken_d = nPC_sel;
                if (stall) begin
                    w_state_d = ST_WAIT;
                end else begin
                    w_pc_d    = w_next_pc;
                    w_state_d = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (!stall) begin
                    w_pc_d    = w_next_pc;
                    w_state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (start) begin
                    w_illegal_d = 1'b0;
                    w_pc_d      = RESET_PC;
                    w_state_d   = ST_FETCH;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= ST_IDLE;
            r_pc_q          <= RESET_PC;
            r_instr_q       <= '0;
            r_br_taken_q    <= 1'b0;
            r_illegal_q     <= 1'b0;
            r_imem_req_q    <= 1'b0;
            r_issue_valid_q <= 1'b0;
            r_halted_q      <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_pc_q          <= w_pc_d;
            r_instr_q       <= w_instr_d;
            r_br_taken_q    <= w_br_taken_d;
            r_illegal_q     <= w_illegal_d;
            r_imem_req_q    <= (w_state_d == ST_FETCH);
            r_issue_valid_q <= (w_state_d == ST_ISSUE);
            r_halted_q      <= (w_state_d == ST_HALT);
        end
    end

    assign imem_req    = r_imem_req_q;
    assign imem_addr   = r_pc_q;
    assign instr       = r_instr_q;
    assign comman      = r_instr_q[OPC_MSB:OPC_LSB];
    assign issue_valid = r_issue_valid_q;
    assign halted      = r_halted_q;
    assign illegal     = r_illegal_q;

endmodule : instr_issue_seq
`default_nettype wire

// File: tb/tb_instr_issue_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_issue_seq
//  Description : Directed self-checking bench for the fetch/issue sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_issue_seq;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata = '0;
    logic          imem_valid = 1'b0;
    logic [5:0]    comman;
    logic [31:0]   instr;
    logic          issue_valid;
    logic          nPC_sel = 1'b0;
    logic          stall = 1'b0;
    logic          halted;
    logic          illegal;

    int n_checks = 0;
    int n_pass   = 0;

    instr_issue_seq #(
        .AW       (AW),
        .RESET_PC (8'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .comman      (comman),
        .instr       (instr),
        .issue_valid (issue_valid),
        .nPC_sel     (nPC_sel),
        .stall       (stall),
        .halted      (halted),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is in FETCH; runs one FETCH(1)+ISSUE(1) slot and checks the next fetch address.
    task automatic do_issue(input string tag, input logic [5:0] op, input logic [15:0] imm,
                            input logic taken, input logic [AW-1:0] exp_next);
        imem_valid = 1'b1;
        imem_rdata = {op, 10'h000, imm};
        tick();
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check({tag, ".issue_valid"}, {31'd0, issue_valid}, 32'd1);
        check({tag, ".comman"}, {26'd0, comman}, {26'd0, op});
        nPC_sel = taken;
        tick();
        nPC_sel = 1'b0;
        check({tag, ".issue_drop"}, {31'd0, issue_valid}, 32'd0);
        check({tag, ".next_addr"}, {24'd0, imem_addr}, {24'd0, exp_next});
        check({tag, ".req"}, {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        int n_issue;
        tick();
        tick();
        rst = 1'b0;
        check("rst.req", {31'd0, imem_req}, 32'd0);
        check("rst.addr", {24'd0, imem_addr}, 32'd0);
        check("rst.instr", instr, 32'd0);
        check("rst.comman", {26'd0, comman}, 32'd0);
        check("rst.issue", {31'd0, issue_valid}, 32'd0);
        check("rst.halted", {31'd0, halted}, 32'd0);
        check("rst.illegal", {31'd0, illegal}, 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start.req", {31'd0, imem_req}, 32'd1);
        check("start.addr", {24'd0, imem_addr}, 32'd0);

        // Sequential stream add/sub/mul at PC 0..2
        do_issue("seq0", 6'b000011, 16'h0000, 1'b0, 8'd1);
        do_issue("seq1", 6'b000100, 16'h0000, 1'b0, 8'd2);
        do_issue("seq2", 6'b000101, 16'h0000, 1'b0, 8'd3);
        do_issue("pad3", 6'b000011, 16'h0000, 1'b0, 8'd4);
        do_issue("pad4", 6'b000011, 16'h0000, 1'b0, 8'd5);

        // beq at 5, imm -3: taken -> 3, not taken -> 6
        do_issue("beq_t", 6'b000010, 16'hFFFD, 1'b1, 8'd3);
        do_issue("pad3b", 6'b000011, 16'h0000, 1'b0, 8'd4);
        do_issue("pad4b", 6'b000011, 16'h0000, 1'b0, 8'd5);
        do_issue("beq_n", 6'b000010, 16'hFFFD, 1'b0, 8'd6);
        do_issue("pad6", 6'b000011, 16'h0000, 1'b0, 8'd7);

        // div at 7 with 4 WAIT cycles and a nPC_sel glitch during WAIT
        imem_valid = 1'b1;
        imem_rdata = {6'b000110, 10'h000, 16'h0010};
        tick();
        imem_valid = 1'b0;
        check("div.issue", {31'd0, issue_valid}, 32'd1);
        stall = 1'b1;
        nPC_sel = 1'b0;
        n_issue = 0;
        for (int w = 0; w < 4; w++) begin
            tick();
            if (issue_valid) n_issue++;
            check("div.wait_req", {31'd0, imem_req}, 32'd0);
            check("div.wait_addr", {24'd0, imem_addr}, 32'd7);
            stall   = (w != 3);
            nPC_sel = w[0];
        end
        tick();
        nPC_sel = 1'b0;
        check("div.extra_issue", n_issue, 32'd0);
        check("div.next_addr", {24'd0, imem_addr}, 32'd8);
        check("div.req", {31'd0, imem_req}, 32'd1);

        // Illegal opcode at 9 halts; stray read data is ignored in HALT
        do_issue("pad8", 6'b000011, 16'h0000, 1'b0, 8'd9);
        imem_valid = 1'b1;
        imem_rdata = 32'h2000_1234;
        tick();
        imem_rdata = 32'h0C00_0000;
        check("ill.halted", {31'd0, halted}, 32'd1);
        check("ill.illegal", {31'd0, illegal}, 32'd1);
        check("ill.issue", {31'd0, issue_valid}, 32'd0);
        check("ill.req", {31'd0, imem_req}, 32'd0);
        tick();
        tick();
        imem_valid = 1'b0;
        check("ill.pc_hold", {24'd0, imem_addr}, 32'd9);
        check("ill.instr_hold", instr, 32'h2000_1234);
        check("ill.comman", {26'd0, comman}, 32'h08);
        check("ill.sticky", {31'd0, illegal}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart.illegal", {31'd0, illegal}, 32'd0);
        check("restart.halted", {31'd0, halted}, 32'd0);
        check("restart.addr", {24'd0, imem_addr}, 32'd0);
        check("restart.req", {31'd0, imem_req}, 32'd1);

        // Wrap-around: 0 -> 255 -> 0 -> 254 -> 4
        do_issue("br_to255", 6'b000010, 16'h00FE, 1'b1, 8'd255);
        do_issue("wrap_seq", 6'b000011, 16'h0000, 1'b0, 8'd0);
        do_issue("br_to254", 6'b000010, 16'h00FD, 1'b1, 8'd254);
        do_issue("wrap_br", 6'b000010, 16'h0005, 1'b1, 8'd4);

        // Reset during FETCH with read data arriving the same cycle
        imem_valid = 1'b1;
        imem_rdata = 32'h0C00_0001;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_valid = 1'b0;
        check("rstf.req", {31'd0, imem_req}, 32'd0);
        check("rstf.instr", instr, 32'd0);
        check("rstf.issue", {31'd0, issue_valid}, 32'd0);
        check("rstf.addr", {24'd0, imem_addr}, 32'd0);
        tick();
        check("rstf.idle_issue", {31'd0, issue_valid}, 32'd0);
        check("rstf.idle_req", {31'd0, imem_req}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_instr_issue_seq
`default_nettype wire
